// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - control FSM to datapath signal bundle
interface mc_ctrl_fsm_if;
  logic [5:0] ir_op;
  logic [5:0] ir_func;
  logic       alu_zero;
  logic       alu_ovf;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       ext_op;
  logic       instr_done;
  logic       ovf_trap;
  logic       illegal;

  modport master (
    input  ir_op, ir_func, alu_zero, alu_ovf,
    output pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
           reg_dst, mem_to_reg, alu_src, alu_op, ext_op, instr_done, ovf_trap, illegal
  );

  modport slave (
    output ir_op, ir_func, alu_zero, alu_ovf,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
           reg_dst, mem_to_reg, alu_src, alu_op, ext_op, instr_done, ovf_trap, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle main control FSM (FETCH/DECODE/EXEC/MEM/WB)
module mc_ctrl_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I = 4'd3,
    EXEC_M  = 4'd4,  MEM_RD = 4'd5,  MEM_WB = 4'd6,  MEM_WR = 4'd7,
    R_WB    = 4'd8,  I_WB   = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_t     state, next_state;
  logic       ovf_trap_q, set_ovf, unknown;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic       reg_dst, mem_to_reg, alu_src, ext_op, instr_done, illegal;
  logic [1:0] pc_src, alu_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      ovf_trap_q <= 1'b0;
    end else begin
      state <= next_state;
      if (set_ovf) ovf_trap_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    set_ovf    = 1'b0;
    unknown    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    ext_op     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (bus.ir_op)
          OP_RTYPE: begin
            if (bus.ir_func == FN_ADDU || bus.ir_func == FN_SUBU || bus.ir_func == FN_SLT)
              next_state = EXEC_R;
            else
              unknown = 1'b1;
          end
          OP_ORI, OP_ADDI, OP_ADDIU, OP_LUI: next_state = EXEC_I;
          OP_LW, OP_SW:                      next_state = EXEC_M;
          OP_BEQ:                            next_state = BRANCH;
          OP_J:                              next_state = JUMP;
          default:                           unknown = 1'b1;
        endcase
        // Untrapped illegal encodings retire here as a two-cycle NOP.
        if (unknown) begin
          if (TRAP_ON_ILLEGAL) begin
            next_state = ILLEGAL;
          end else begin
            next_state = FETCH;
            instr_done = 1'b1;
          end
        end
      end
      EXEC_R: begin
        alu_op     = 2'b01;
        next_state = R_WB;
      end
      EXEC_I: begin
        alu_src = 1'b1;
        case (bus.ir_op)
          OP_ORI:            alu_op = 2'b10;
          OP_ADDI, OP_ADDIU: ext_op = 1'b1;
          default:           ext_op = 1'b0;
        endcase
        next_state = I_WB;
      end
      EXEC_M: begin
        alu_src    = 1'b1;
        ext_op     = 1'b1;
        next_state = (bus.ir_op == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        next_state = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      I_WB: begin
        // A signed-overflowing addi must not commit its result.
        if (bus.ir_op == OP_ADDI && bus.alu_ovf) set_ovf = 1'b1;
        else reg_write = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = bus.alu_zero;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      ILLEGAL: begin
        illegal    = 1'b1;
        next_state = ILLEGAL;
      end
      default: next_state = FETCH;
    endcase
    if (reset) begin
      set_ovf    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      ext_op     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.iord       = iord;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.ext_op     = ext_op;
  assign bus.instr_done = instr_done;
  assign bus.ovf_trap   = ovf_trap_q;
  assign bus.illegal    = illegal;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm_if bus();
  mc_ctrl_fsm_if bus_nop();

  mc_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut     (.clk(clk), .reset(reset), .bus(bus));
  mc_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (.clk(clk), .reset(reset), .bus(bus_nop));

  always #5 clk = ~clk;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3;
  localparam logic [3:0] S_EXEC_M = 4'd4, S_MEM_RD = 4'd5, S_MEM_WB = 4'd6, S_MEM_WR = 4'd7;
  localparam logic [3:0] S_R_WB = 4'd8, S_I_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  // {pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
  //  reg_dst, mem_to_reg, alu_src, alu_op, ext_op, instr_done, illegal}
  localparam logic [15:0] V_FETCH   = 16'b1_00_1_1_0_0_0_0_0_0_00_0_0_0;
  localparam logic [15:0] V_DECODE  = 16'b0_00_0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [15:0] V_EXEC_R  = 16'b0_00_0_0_0_0_0_0_0_0_01_0_0_0;
  localparam logic [15:0] V_R_WB    = 16'b0_00_0_0_0_0_1_1_0_0_00_0_1_0;
  localparam logic [15:0] V_EXEC_M  = 16'b0_00_0_0_0_0_0_0_0_1_00_1_0_0;
  localparam logic [15:0] V_MEM_RD  = 16'b0_00_0_1_0_1_0_0_0_0_00_0_0_0;
  localparam logic [15:0] V_MEM_WB  = 16'b0_00_0_0_0_0_1_0_1_0_00_0_1_0;
  localparam logic [15:0] V_MEM_WR  = 16'b0_00_0_0_1_1_0_0_0_0_00_0_1_0;
  localparam logic [15:0] V_BR_TKN  = 16'b1_01_0_0_0_0_0_0_0_0_01_0_1_0;
  localparam logic [15:0] V_BR_NT   = 16'b0_01_0_0_0_0_0_0_0_0_01_0_1_0;
  localparam logic [15:0] V_EXEC_AI = 16'b0_00_0_0_0_0_0_0_0_1_00_1_0_0;
  localparam logic [15:0] V_EXEC_OR = 16'b0_00_0_0_0_0_0_0_0_1_10_0_0_0;
  localparam logic [15:0] V_I_WB    = 16'b0_00_0_0_0_0_1_0_0_0_00_0_1_0;
  localparam logic [15:0] V_I_WB_OV = 16'b0_00_0_0_0_0_0_0_0_0_00_0_1_0;
  localparam logic [15:0] V_ILLEGAL = 16'b0_00_0_0_0_0_0_0_0_0_00_0_0_1;
  localparam logic [15:0] V_NOP_DEC = 16'b0_00_0_0_0_0_0_0_0_0_00_0_1_0;

  wire [15:0] obs = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                     bus.iord, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src,
                     bus.alu_op, bus.ext_op, bus.instr_done, bus.illegal};
  wire [15:0] obs_nop = {bus_nop.pc_write, bus_nop.pc_src, bus_nop.ir_write, bus_nop.mem_read,
                         bus_nop.mem_write, bus_nop.iord, bus_nop.reg_write, bus_nop.reg_dst,
                         bus_nop.mem_to_reg, bus_nop.alu_src, bus_nop.alu_op, bus_nop.ext_op,
                         bus_nop.instr_done, bus_nop.illegal};
  logic [3:0] st, st_nop;
  assign st     = dut.state;
  assign st_nop = dut_nop.state;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_addu();
    logic [3:0]  es [4];
    logic [15:0] ev [4];
    es = '{S_FETCH, S_DECODE, S_EXEC_R, S_R_WB};
    ev = '{V_FETCH, V_DECODE, V_EXEC_R, V_R_WB};
    reset = 1'b1;
    bus.ir_op = 6'b000000; bus.ir_func = 6'b100001;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== 16'h0000 || st !== S_FETCH || bus.ovf_trap !== 1'b0) begin
        errors++;
        $display("FAIL reset_cyc%0d: state=%0d outs=%h ovf=%b, want state=%0d outs=0000 ovf=0",
                 c, st, obs, bus.ovf_trap, S_FETCH);
      end
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st !== es[i] || obs !== ev[i]) begin
        errors++;
        $display("FAIL addu_cyc%0d: state=%0d outs=%h, want state=%0d outs=%h", i, st, obs, es[i], ev[i]);
      end
      tick();
    end
    checks++;
    if (st !== S_FETCH) begin
      errors++;
      $display("FAIL addu_return: state=%0d, want %0d", st, S_FETCH);
    end
  endtask

  task automatic test_lw_sw();
    logic [3:0]  es [5];
    logic [15:0] ev [5];
    int done_cnt;
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 5 : 4;
      bus.ir_op = (k == 0) ? 6'b100011 : 6'b101011;
      if (k == 0) begin
        es = '{S_FETCH, S_DECODE, S_EXEC_M, S_MEM_RD, S_MEM_WB};
        ev = '{V_FETCH, V_DECODE, V_EXEC_M, V_MEM_RD, V_MEM_WB};
      end else begin
        es = '{S_FETCH, S_DECODE, S_EXEC_M, S_MEM_WR, S_FETCH};
        ev = '{V_FETCH, V_DECODE, V_EXEC_M, V_MEM_WR, V_FETCH};
      end
      #1;
      done_cnt = 0;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (st !== es[i] || obs !== ev[i]) begin
          errors++;
          $display("FAIL %s_cyc%0d: state=%0d outs=%h, want state=%0d outs=%h",
                   (k == 0) ? "lw" : "sw", i, st, obs, es[i], ev[i]);
        end
        if (obs[1]) done_cnt++;
        tick();
      end
      checks++;
      if (done_cnt !== 1 || st !== S_FETCH) begin
        errors++;
        $display("FAIL %s_done: pulses=%0d state=%0d, want pulses=1 state=%0d",
                 (k == 0) ? "lw" : "sw", done_cnt, st, S_FETCH);
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0]  es [3];
    logic [15:0] ev [3];
    bus.ir_op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      bus.alu_zero = (k == 0);
      es = '{S_FETCH, S_DECODE, S_BRANCH};
      ev = '{V_FETCH, V_DECODE, (k == 0) ? V_BR_TKN : V_BR_NT};
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (st !== es[i] || obs !== ev[i]) begin
          errors++;
          $display("FAIL beq_z%0d_cyc%0d: state=%0d outs=%h, want state=%0d outs=%h",
                   1 - k, i, st, obs, es[i], ev[i]);
        end
        tick();
      end
      checks++;
      if (st !== S_FETCH) begin
        errors++;
        $display("FAIL beq_z%0d_return: state=%0d, want %0d", 1 - k, st, S_FETCH);
      end
    end
    bus.alu_zero = 1'b0;
  endtask

  task automatic test_ovf_trap();
    logic [3:0]  es [4];
    logic [15:0] ev [4];
    bus.alu_ovf = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.ir_op = (k == 0) ? 6'b001001 : 6'b001000;
      es = '{S_FETCH, S_DECODE, S_EXEC_I, S_I_WB};
      ev = '{V_FETCH, V_DECODE, V_EXEC_AI, (k == 0) ? V_I_WB : V_I_WB_OV};
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (st !== es[i] || obs !== ev[i]) begin
          errors++;
          $display("FAIL %s_cyc%0d: state=%0d outs=%h, want state=%0d outs=%h",
                   (k == 0) ? "addiu" : "addi", i, st, obs, es[i], ev[i]);
        end
        tick();
      end
      checks++;
      if (bus.ovf_trap !== (k == 1)) begin
        errors++;
        $display("FAIL %s_ovf_trap: got %b, want %b", (k == 0) ? "addiu" : "addi", bus.ovf_trap, k == 1);
      end
    end
    bus.alu_ovf = 1'b0;
    bus.ir_op = 6'b000010;
    #1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.ovf_trap !== 1'b1 || st !== S_FETCH) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b state=%0d, want ovf=1 state=%0d", bus.ovf_trap, st, S_FETCH);
    end
  endtask

  task automatic test_illegal();
    bus.ir_op = 6'b111111;
    bus_nop.ir_op = 6'b111111;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (st !== S_FETCH || obs !== V_FETCH || st_nop !== S_FETCH || obs_nop !== V_FETCH) begin
      errors++;
      $display("FAIL ill_fetch: state=%0d/%0d outs=%h/%h, want state=%0d outs=%h",
               st, st_nop, obs, obs_nop, S_FETCH, V_FETCH);
    end
    tick();
    checks++;
    if (st !== S_DECODE || obs !== V_DECODE || st_nop !== S_DECODE || obs_nop !== V_NOP_DEC) begin
      errors++;
      $display("FAIL ill_decode: state=%0d/%0d outs=%h/%h, want state=%0d outs=%h/%h",
               st, st_nop, obs, obs_nop, S_DECODE, V_DECODE, V_NOP_DEC);
    end
    tick();
    checks++;
    if (st_nop !== S_FETCH || obs_nop !== V_FETCH) begin
      errors++;
      $display("FAIL nop_return: state=%0d outs=%h, want state=%0d outs=%h", st_nop, obs_nop, S_FETCH, V_FETCH);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (st !== S_ILLEGAL || obs !== V_ILLEGAL) begin
        errors++;
        $display("FAIL ill_hold%0d: state=%0d outs=%h, want state=%0d outs=%h", i, st, obs, S_ILLEGAL, V_ILLEGAL);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (st !== S_FETCH || obs !== V_FETCH) begin
      errors++;
      $display("FAIL ill_reset: state=%0d outs=%h, want state=%0d outs=%h", st, obs, S_FETCH, V_FETCH);
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [3:0]  es [4];
    logic [15:0] ev [4];
    bus.ir_op = 6'b101011;
    #1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (st !== S_MEM_WR || obs !== V_MEM_WR) begin
      errors++;
      $display("FAIL sw_memwr: state=%0d outs=%h, want state=%0d outs=%h", st, obs, S_MEM_WR, V_MEM_WR);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL abort_outs: outs=%h, want 0000", obs);
    end
    tick();
    reset = 1'b0;
    bus.ir_op = 6'b001101;
    #1;
    es = '{S_FETCH, S_DECODE, S_EXEC_I, S_I_WB};
    ev = '{V_FETCH, V_DECODE, V_EXEC_OR, V_I_WB};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st !== es[i] || obs !== ev[i]) begin
        errors++;
        $display("FAIL ori_cyc%0d: state=%0d outs=%h, want state=%0d outs=%h", i, st, obs, es[i], ev[i]);
      end
      tick();
    end
  endtask

  initial begin
    bus.ir_op = 6'b0; bus.ir_func = 6'b0; bus.alu_zero = 1'b0; bus.alu_ovf = 1'b0;
    bus_nop.ir_op = 6'b0; bus_nop.ir_func = 6'b100001; bus_nop.alu_zero = 1'b0; bus_nop.alu_ovf = 1'b0;
    test_reset_addu();
    test_lw_sw();
    test_beq();
    test_ovf_trap();
    test_illegal();
    test_reset_mid_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
